linescan_sensor_emulator: RTL

- Behavioural-synthesizable stand-in for the 128-pixel linear CCD on the sensor side of the SI/CLK interface.
- Samples the SI pulse and sensor clock produced by the sensor driver, runs a readout frame, and emits one digital pixel word per sensor-clock period after a programmable settling delay.
- Used in loopback bring-up on the FPGA and as the DUT-side model in driver testbenches.

---
 rtl/linescan_sensor_emulator.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/linescan_sensor_emulator.sv
// Line-scan CCD stand-in: samples SI/CLK from a sensor driver, runs a readout
// frame and emits one pattern word per sensor-clock period after a settle delay.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// ST_IDLE    | waiting for a sensor-clock rise with SI high to start a frame
// ST_READOUT | frame active; settle timer runs from the last rise, one pixel
//            | strobe per rise, frame ends on the rise after the last pixel
module linescan_sensor_emulator #(
    parameter int NUMBER_OF_PIXEL = 128,
    parameter int DATA_WIDTH      = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int SETTLE_NCLK     = 35,
    parameter int RAMP_STEP       = 16
) (
    input  logic                  master_clock,
    input  logic                  resetn,
    input  logic                  sensor_clk_in,
    input  logic                  si_in,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] pattern_const,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic [7:0]            pixel_index,
    output logic                  pixel_valid,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  missed_pixel,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int CNT_W = (SETTLE_NCLK > 1) ? $clog2(SETTLE_NCLK) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_NCLK - 1);
    localparam logic [7:0]       LAST_IDX    = 8'(NUMBER_OF_PIXEL - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_READOUT = 1'b1
    } state_t;

    // Word generator; every pattern wraps modulo 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] pattern_word(
        input logic [1:0]            sel,
        input logic [7:0]            idx,
        input logic [DATA_WIDTH-1:0] cst,
        input logic [15:0]           fcnt
    );
        logic [DATA_WIDTH-1:0] ramp;
        logic [DATA_WIDTH-1:0] word;
        ramp = DATA_WIDTH'(idx) * DATA_WIDTH'(RAMP_STEP);
        word = '0;
        case (sel)
            2'd0:    word = ramp;
            2'd1:    word = cst;
            2'd2:    word = idx[0] ? '1 : '0;
            default: word = ramp + DATA_WIDTH'(fcnt);
        endcase
        return word;
    endfunction

    logic [1:0]             rst_sync;
    logic                   rst_int_n;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] si_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   si_s;
    logic                   clk_rise;

    state_t                 state,       state_nxt;
    logic [7:0]             cur_idx,     cur_idx_nxt;
    logic [CNT_W-1:0]       settle_cnt,  settle_nxt;
    logic                   pending,     pending_nxt;
    logic [1:0]             pat_sel_q,   pat_sel_nxt;
    logic [DATA_WIDTH-1:0]  pat_const_q, pat_const_nxt;
    logic [DATA_WIDTH-1:0]  pixel_data_nxt;
    logic [7:0]             pixel_index_nxt;
    logic                   pixel_valid_nxt;
    logic                   frame_done_nxt;
    logic                   frame_error_nxt;
    logic                   missed_nxt;
    logic [15:0]            frame_count_nxt;
    logic                   settle_expired;
    logic [DATA_WIDTH-1:0]  strobe_word;

    // Reset: asserts asynchronously, releases on a clock edge.
    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Bring the asynchronous driver signals into the master_clock domain.
    always_ff @(posedge master_clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sclk_sync <= '0;
            si_sync   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sensor_clk_in};
            si_sync   <= {si_sync[SYNC_STAGES-2:0], si_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign si_s     = si_sync[SYNC_STAGES-1];
    assign clk_rise = sclk_s & ~sclk_prev;

    // Settle timer reaching zero with a pixel still owed means the strobe goes
    // out now, even if the next rise lands in the same cycle.
    assign settle_expired = pending && (settle_cnt == '0);
    assign strobe_word    = pattern_word(pat_sel_q, cur_idx, pat_const_q, frame_count);
    assign busy           = (state == ST_READOUT);

    // State and datapath registers.
    always_ff @(posedge master_clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= ST_IDLE;
            cur_idx      <= '0;
            settle_cnt   <= '0;
            pending      <= 1'b0;
            pat_sel_q    <= '0;
            pat_const_q  <= '0;
            pixel_data   <= '0;
            pixel_index  <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            missed_pixel <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_nxt;
            cur_idx      <= cur_idx_nxt;
            settle_cnt   <= settle_nxt;
            pending      <= pending_nxt;
            pat_sel_q    <= pat_sel_nxt;
            pat_const_q  <= pat_const_nxt;
            pixel_data   <= pixel_data_nxt;
            pixel_index  <= pixel_index_nxt;
            pixel_valid  <= pixel_valid_nxt;
            frame_done   <= frame_done_nxt;
            frame_error  <= frame_error_nxt;
            missed_pixel <= missed_nxt;
            frame_count  <= frame_count_nxt;
        end
    end

    // Next-state and output decisions for the readout sequence.
    always_comb begin
        state_nxt       = state;
        cur_idx_nxt     = cur_idx;
        settle_nxt      = settle_cnt;
        pending_nxt     = pending;
        pat_sel_nxt     = pat_sel_q;
        pat_const_nxt   = pat_const_q;
        pixel_data_nxt  = pixel_data;
        pixel_index_nxt = pixel_index;
        pixel_valid_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        frame_error_nxt = 1'b0;
        missed_nxt      = missed_pixel;
        frame_count_nxt = frame_count;

        case (state)
            ST_IDLE: begin
                if (clk_rise && si_s) begin
                    state_nxt     = ST_READOUT;
                    cur_idx_nxt   = '0;
                    settle_nxt    = SETTLE_LOAD;
                    pending_nxt   = 1'b1;
                    pat_sel_nxt   = pattern_sel;
                    pat_const_nxt = pattern_const;
                    missed_nxt    = 1'b0;
                end
            end

            ST_READOUT: begin
                if (settle_cnt != '0) begin
                    settle_nxt = settle_cnt - CNT_W'(1);
                end

                if (settle_expired) begin
                    pixel_valid_nxt = 1'b1;
                    pixel_data_nxt  = strobe_word;
                    pixel_index_nxt = cur_idx;
                    pending_nxt     = 1'b0;
                end

                if (clk_rise) begin
                    if (si_s) begin
                        // SI mid-frame: abandon this frame and start over.
                        frame_error_nxt = 1'b1;
                        cur_idx_nxt     = '0;
                        settle_nxt      = SETTLE_LOAD;
                        pending_nxt     = 1'b1;
                        pat_sel_nxt     = pattern_sel;
                        pat_const_nxt   = pattern_const;
                    end else begin
                        if (pending && !settle_expired) begin
                            missed_nxt = 1'b1;
                        end
                        if (cur_idx == LAST_IDX) begin
                            frame_done_nxt  = 1'b1;
                            frame_count_nxt = frame_count + 16'd1;
                            state_nxt       = ST_IDLE;
                            pending_nxt     = 1'b0;
                        end else begin
                            cur_idx_nxt = cur_idx + 8'd1;
                            settle_nxt  = SETTLE_LOAD;
                            pending_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
